// File: rtl/result_writeback_unit_pkg.sv
// Shared types and constants for the result write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, kernel-size legality limits, counter width helper.
package result_writeback_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } wb_state_t;

   localparam int KER_MIN             = 1;
   localparam int DEF_MAX_IMG_WIDTH   = 28;
   localparam int DEF_MAX_KERNEL_SIZE = 5;

   // Width of a counter that must hold 0..max_img^2 inclusive.
   function automatic int cnt_width(input int max_img);
      return $clog2(max_img * max_img + 1);
   endfunction

   localparam int DEF_CNT_W = cnt_width(DEF_MAX_IMG_WIDTH);

   // A kernel is usable only if it is non-zero, within the supported size
   // and not larger than the image itself.
   function automatic logic ker_legal(input logic [2:0] ker,
                                      input int max_ker,
                                      input int max_img);
      return (int'(ker) >= KER_MIN) && (int'(ker) <= max_ker) && (int'(ker) <= max_img);
   endfunction

endpackage

// File: rtl/result_writeback_unit_if.sv
// Result stream + BRAM write port bundle between PE array, unit and arbiter.
// Latency: n/a (wires only).
// Backpressure: res_ready (stream side), bram_gnt (BRAM side).
// slave modport = write-back unit; master modport = surrounding environment.
interface result_writeback_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   logic                  res_valid;
   logic [DATA_WIDTH-1:0] res_data;
   logic                  res_ready;
   logic                  bram_gnt;
   logic                  bram_en;
   logic                  bram_we;
   logic [ADDR_WIDTH-1:0] bram_addr;
   logic [DATA_WIDTH-1:0] bram_dout;

   modport slave (
      input  res_valid, res_data, bram_gnt,
      output res_ready, bram_en, bram_we, bram_addr, bram_dout
   );

   modport master (
      output res_valid, res_data, bram_gnt,
      input  res_ready, bram_en, bram_we, bram_addr, bram_dout
   );
endinterface

// File: rtl/result_writeback_unit_wb_sync_fifo.sv
// Small synchronous FIFO buffering result words ahead of the BRAM port.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: full/empty are registered; push when full / pop when empty are dropped.
// Ports: clk, rst (sync, high), push/push_data, pop, head, full, empty.
module wb_sync_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  full,
   output logic                  empty
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic [AW:0]           count_next;
   logic                  full_q;
   logic                  empty_q;
   logic                  do_push;
   logic                  do_pop;

   assign do_push = push && !full_q;
   assign do_pop  = pop && !empty_q;

   always_comb begin
      count_next = count;
      case ({do_push, do_pop})
         2'b10:   count_next = count + (AW+1)'(1);
         2'b01:   count_next = count - (AW+1)'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count   <= count_next;
         full_q  <= (count_next == (AW+1)'(DEPTH));
         empty_q <= (count_next == '0);
      end
   end

   // Storage needs no reset: nothing is read while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign full  = full_q;
   assign empty = empty_q;
endmodule

// File: rtl/result_writeback_unit.sv
// Writes a frame of PE results row-major into BRAM from base_addr, out_dim^2 words.
// Latency: word accepted at cycle N into an empty buffer appears on the BRAM port at N+1.
// Backpressure: res_ready drops on full buffer or once the frame's word count is taken; writes stall on bram_gnt=0.
// Ports: clk/rst, start/base_addr/ker_size config, bus (result stream + BRAM port), busy/frame_done/cfg_err status.
module result_writeback_unit
   import result_writeback_unit_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 12,
   parameter int MAX_IMG_WIDTH   = DEF_MAX_IMG_WIDTH,
   parameter int MAX_KERNEL_SIZE = DEF_MAX_KERNEL_SIZE,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [2:0]            ker_size,
   result_writeback_unit_if.slave bus,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  cfg_err
);
   localparam int CNT_W = cnt_width(MAX_IMG_WIDTH);
   localparam int DIM_W = $clog2(MAX_IMG_WIDTH + 1);

   wb_state_t             state_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [DIM_W-1:0]      out_dim_q;
   logic [DIM_W-1:0]      row_q;
   logic [DIM_W-1:0]      col_q;
   logic [CNT_W-1:0]      total_q;
   logic [CNT_W-1:0]      acc_q;
   logic                  busy_q;
   logic                  frame_done_q;
   logic                  cfg_err_q;

   logic [DIM_W-1:0]      dim_start;
   logic [CNT_W-1:0]      dim_ext;
   logic [CNT_W-1:0]      total_start;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  push;
   logic                  pop;
   logic                  wr_en;
   logic                  last_col;
   logic                  last_row;

   // Frame geometry from the incoming ker_size; only used when it is legal.
   assign dim_start   = DIM_W'(MAX_IMG_WIDTH + 1 - int'(ker_size));
   assign dim_ext     = CNT_W'(dim_start);
   assign total_start = dim_ext * dim_ext;

   assign wr_en    = (state_q == ST_RUN) && !fifo_empty;
   assign push     = bus.res_valid && bus.res_ready;
   assign pop      = wr_en && bus.bram_gnt;
   assign last_col = (col_q == out_dim_q - DIM_W'(1));
   assign last_row = (row_q == out_dim_q - DIM_W'(1));

   assign bus.res_ready = (state_q == ST_RUN) && !fifo_full && (acc_q < total_q);
   assign bus.bram_en   = wr_en;
   assign bus.bram_we   = wr_en;
   assign bus.bram_addr = wr_en ? wr_addr_q : '0;
   assign bus.bram_dout = wr_en ? fifo_head : '0;

   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign cfg_err    = cfg_err_q;

   wb_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (bus.res_data),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // wr_addr_q tracks base + row*out_dim + col incrementally: row-major order
   // makes that sum advance by exactly one per completed write, so no
   // multiplier sits in the address path. Wrap is modulo 2^ADDR_WIDTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         wr_addr_q    <= '0;
         out_dim_q    <= '0;
         row_q        <= '0;
         col_q        <= '0;
         total_q      <= '0;
         acc_q        <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (ker_legal(ker_size, MAX_KERNEL_SIZE, MAX_IMG_WIDTH)) begin
                     wr_addr_q <= base_addr;
                     out_dim_q <= dim_start;
                     total_q   <= total_start;
                     row_q     <= '0;
                     col_q     <= '0;
                     acc_q     <= '0;
                     busy_q    <= 1'b1;
                     state_q   <= ST_RUN;
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (push) acc_q <= acc_q + CNT_W'(1);
               if (pop) begin
                  wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
                  if (last_col) begin
                     col_q <= '0;
                     row_q <= row_q + DIM_W'(1);
                  end else begin
                     col_q <= col_q + DIM_W'(1);
                  end
                  if (last_col && last_row) begin
                     state_q      <= ST_DONE;
                     frame_done_q <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_result_writeback_unit.sv
// Bench for result_writeback_unit with an 8x8 image: frame-level model plus directed vectors.
// Latency: n/a.
// Backpressure: bench drives res_valid/bram_gnt and honours res_ready.
module tb_result_writeback_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [11:0] base_addr;
   logic [2:0]  ker_size;
   logic        busy;
   logic        frame_done;
   logic        cfg_err;

   result_writeback_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) bus ();

   result_writeback_unit #(
      .DATA_WIDTH      (32),
      .ADDR_WIDTH      (12),
      .MAX_IMG_WIDTH   (8),
      .MAX_KERNEL_SIZE (5),
      .FIFO_DEPTH      (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .ker_size   (ker_size),
      .bus        (bus),
      .busy       (busy),
      .frame_done (frame_done),
      .cfg_err    (cfg_err)
   );

   always #5 clk = ~clk;

   int vec_cnt  = 0;
   int miss_cnt = 0;
   int fd_cnt   = 0;
   int cfg_cnt  = 0;
   bit chk_en   = 0;

   // Frame-level model: phase 0 idle, 1 running, 2 done-pulse cycle.
   int ph      = 0;
   int m_base  = 0;
   int m_total = 0;
   int m_acc   = 0;
   int m_wr    = 0;
   bit m_cfg   = 0;
   int mq[$];
   int log_addr[$];
   int log_data[$];
   bit e_en, e_rdy;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      vec_cnt++;
      miss_cnt++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         e_rdy = (ph == 1) && (mq.size() < 4) && (m_acc < m_total);
         e_en  = (ph == 1) && (mq.size() > 0);
         chk("busy", busy, ph != 0);
         chk("frame_done", frame_done, ph == 2);
         chk("cfg_err", cfg_err, m_cfg);
         chk("res_ready", bus.res_ready, e_rdy);
         chk("bram_en", bus.bram_en, e_en);
         chk("bram_we", bus.bram_we, e_en);
         if (e_en) begin
            chk("bram_addr", bus.bram_addr, (m_base + m_wr) % 4096);
            chk("bram_dout", bus.bram_dout, mq[0]);
         end
         if (frame_done) fd_cnt++;
         if (cfg_err) cfg_cnt++;
         if (rst) begin
            ph = 0;
            mq.delete();
            m_cfg = 0;
         end else begin
            m_cfg = 0;
            case (ph)
               0: if (start) begin
                  if (ker_size >= 1 && ker_size <= 5) begin
                     ph      = 1;
                     m_base  = base_addr;
                     m_total = (9 - ker_size) * (9 - ker_size);
                     m_acc   = 0;
                     m_wr    = 0;
                     mq.delete();
                  end else begin
                     m_cfg = 1;
                  end
               end
               1: begin
                  if (e_en && bus.bram_gnt) begin
                     log_addr.push_back(bus.bram_addr);
                     log_data.push_back(bus.bram_dout);
                     void'(mq.pop_front());
                     m_wr++;
                  end
                  if (e_rdy && bus.res_valid) begin
                     mq.push_back(bus.res_data);
                     m_acc++;
                  end
                  if (m_wr == m_total) ph = 2;
               end
               default: ph = 0;
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [11:0] b, input logic [2:0] k);
      start = 1'b1; base_addr = b; ker_size = k;
      tick();
      start = 1'b0;
   endtask

   task automatic send_words(input int n, input int d0, input bit gaps);
      for (int i = 0; i < n; i++) begin
         int g;
         int t;
         g = gaps ? ((i * 5 + 1) % 3) : 0;
         bus.res_valid = 1'b0;
         repeat (g) tick();
         bus.res_valid = 1'b1;
         bus.res_data  = d0 + i;
         t = 0;
         @(negedge clk);
         while (!bus.res_ready && t < 200) begin
            @(negedge clk);
            t++;
         end
         if (t >= 200) begin
            timeout("send_word");
            bus.res_valid = 1'b0;
            return;
         end
         tick();
      end
      bus.res_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int t;
      t = 0;
      while (fd_cnt < target && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (fd_cnt < target) timeout("frame_done");
      tick();
      tick();
   endtask

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
   endtask

   initial begin
      int t;
      rst = 1'b1; start = 1'b0; base_addr = '0; ker_size = '0;
      bus.res_valid = 1'b0; bus.res_data = '0; bus.bram_gnt = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk_en = 1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_en", bus.bram_en, 0);
      chk("rst_we", bus.bram_we, 0);
      chk("rst_addr", bus.bram_addr, 0);
      chk("rst_dout", bus.bram_dout, 0);
      chk("rst_ready", bus.res_ready, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_cfg", cfg_err, 0);
      tick();

      // Back-to-back 4x4 frame; a second start while busy must be ignored.
      clear_log();
      start_frame(12'h100, 3'd5);
      start_frame(12'h000, 3'd1);
      send_words(16, 0, 0);
      wait_done(1);
      chk("t1_count", log_addr.size(), 16);
      chk("t1_addr0", log_addr[0], 32'h100);
      chk("t1_addr15", log_addr[15], 32'h10F);
      chk("t1_data15", log_data[15], 15);
      @(negedge clk);
      chk("t1_busy_after", busy, 0);
      tick();

      // Illegal kernel sizes.
      clear_log();
      start_frame(12'h000, 3'd0);
      tick(); tick();
      start_frame(12'h000, 3'd6);
      tick(); tick();
      chk("t5_cfg_pulses", cfg_cnt, 2);
      chk("t5_no_writes", log_addr.size(), 0);

      // 6x6 frame with gaps, then an extra word that must not be taken.
      clear_log();
      start_frame(12'h040, 3'd3);
      send_words(36, 32'h1000, 1);
      bus.res_valid = 1'b1;
      bus.res_data  = 32'h99;
      @(negedge clk);
      chk("t2_ready_at_total", bus.res_ready, 0);
      chk("t2_busy_at_total", busy, 1);
      tick();
      repeat (4) tick();
      bus.res_valid = 1'b0;
      wait_done(2);
      chk("t2_count", log_addr.size(), 36);
      chk("t2_addr35", log_addr[35], 32'h063);
      chk("t2_data35", log_data[35], 32'h1023);

      // 7x7 frame with the grant withheld for 10 cycles.
      clear_log();
      bus.bram_gnt = 1'b0;
      start_frame(12'h300, 3'd2);
      fork
         send_words(49, 32'h2000, 0);
         begin
            repeat (10) @(posedge clk);
            @(negedge clk);
            chk("t3_stall_ready", bus.res_ready, 0);
            chk("t3_stall_en", bus.bram_en, 1);
            chk("t3_stall_addr", bus.bram_addr, 32'h300);
            chk("t3_stall_dout", bus.bram_dout, 32'h2000);
            chk("t3_stall_taken", m_acc, 4);
            tick();
            bus.bram_gnt = 1'b1;
         end
      join
      wait_done(3);
      chk("t3_count", log_addr.size(), 49);
      chk("t3_addr48", log_addr[48], 32'h330);
      chk("t3_data48", log_data[48], 32'h2030);

      // Address wrap at the top of the BRAM.
      clear_log();
      start_frame(12'hFF8, 3'd5);
      send_words(16, 32'h3000, 0);
      wait_done(4);
      chk("t4_addr7", log_addr[7], 32'hFFF);
      chk("t4_addr8", log_addr[8], 32'h000);
      chk("t4_addr15", log_addr[15], 32'h007);

      // Reset mid-frame, then restart elsewhere.
      clear_log();
      start_frame(12'h400, 3'd5);
      send_words(5, 32'h4000, 0);
      t = 0;
      while (log_addr.size() < 5 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (log_addr.size() < 5) timeout("t6_five_writes");
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_en", bus.bram_en, 0);
      chk("t6_rst_ready", bus.res_ready, 0);
      chk("t6_rst_addr", bus.bram_addr, 0);
      chk("t6_rst_fd", frame_done, 0);
      tick();
      clear_log();
      start_frame(12'h200, 3'd5);
      send_words(16, 32'h5000, 0);
      wait_done(5);
      chk("t6_addr0", log_addr[0], 32'h200);
      chk("t6_data0", log_data[0], 32'h5000);
      chk("t6_count", log_addr.size(), 16);
      chk("fd_total", fd_cnt, 5);
      chk("cfg_total", cfg_cnt, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end
endmodule

// File: doc/result_writeback_unit.md
Name: result_writeback_unit

Overview:
Write-side counterpart of the image fetch path. It accepts the convolution/PE result stream over a valid/ready handshake, buffers it in a small FIFO, and writes each result row-major into the output BRAM region starting at base_addr. It sits between the PE array output and a shared BRAM port whose write slot is granted by an external arbiter. It signals frame completion after the last of out_dim x out_dim results is written.

Parameters:
DATA_WIDTH, 32, result word width
ADDR_WIDTH, 12, BRAM address width
MAX_IMG_WIDTH, 28, input image side length (square image)
MAX_KERNEL_SIZE, 5, largest legal ker_size
FIFO_DEPTH, 4, result buffer depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
base_addr  in  ADDR_WIDTH  first output word address; sampled on accepted start
ker_size  in  3  kernel side, legal 1..MAX_KERNEL_SIZE; sampled on accepted start
res_valid  in  1  result word present
res_data  in  DATA_WIDTH  result word
res_ready  out  1  unit accepts res_data this cycle
bram_gnt  in  1  arbiter grants BRAM write slot this cycle
bram_en  out  1  BRAM enable
bram_we  out  1  BRAM write enable
bram_addr  out  ADDR_WIDTH  write address
bram_dout  out  DATA_WIDTH  write data
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after last write
cfg_err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO flushed; counters 0. Reset mid-frame aborts the frame with no frame_done; the next start restarts at the new base_addr.
- out_dim = MAX_IMG_WIDTH - ker_size + 1; total = out_dim*out_dim. Computed on start with clog2-sized unsigned counters.
- IDLE: start with ker_size in 1..MAX_KERNEL_SIZE and ker_size <= MAX_IMG_WIDTH: latch config, go RUN, busy=1 next cycle. An illegal ker_size (0, >MAX_KERNEL_SIZE) pulses cfg_err next cycle and the FSM stays IDLE.
- RUN: res_ready = !fifo_full && (accepted < total). A transfer occurs when res_valid && res_ready. Words beyond total are never accepted.
- Write: when the FIFO is non-empty, bram_en=bram_we=1 and bram_addr = base + row*out_dim + col (row-major). bram_dout is the FIFO head. The write completes on a cycle where bram_gnt=1; only then are the head popped and row/col advanced.
- Address, data and enable outputs hold steady while bram_gnt=0 and are driven combinationally from registered state.
- Address arithmetic is modulo 2^ADDR_WIDTH (wraps silently).
- Latency: a word accepted at cycle N into an empty FIFO is presented on the BRAM port at N+1.
- Simultaneous push and pop is legal and the FIFO count is unchanged. res_ready uses the registered full flag, so there is no same-cycle pop-to-ready path.
- After the write with index total-1 completes: go DONE, pulse frame_done for one cycle, then return to IDLE with busy=0.
- start while busy is ignored, with no cfg_err.
- bram_en=0 whenever the FIFO is empty or the FSM is not RUN.

Decomposition:
- Shared package: FSM state enum (IDLE, RUN, DONE), ker_size legality limits, and a clog2-based counter width constant for MAX_IMG_WIDTH^2.
- One natural sub-module: wb_sync_fifo, a parameterised DATA_WIDTH x FIFO_DEPTH synchronous FIFO with full/empty flags and sync reset.

Test Plan:
- MAX_IMG_WIDTH=8, base=0x100, ker=5, bram_gnt=1, res_data 0..15 back-to-back -> 16 writes at 0x100..0x10F with data 0..15; frame_done one cycle after the 0x10F write; busy then 0.
- ker=3 with random res_valid gaps -> exactly 36 writes at base..base+35 in order; no lost or duplicated words; a 37th offered word is not accepted.
- ker=2 with bram_gnt held 0 for 10 cycles -> res_ready drops after 4 words and bram_addr/bram_dout hold; after grant, 49 writes complete in order.
- base=0xFF8, ker=5 -> addresses 0xFF8..0xFFF then 0x000..0x007.
- start with ker=0, then ker=6 -> cfg_err pulse each time; no bram_en; busy stays 0. A start during a busy frame is ignored.
- rst asserted after 5 writes of a ker=5 frame -> all outputs 0 next cycle and no frame_done; a new start at base=0x200 writes 0x200 first.
